// File: rtl/poly_eval.sv
// Horner-method polynomial evaluator: y = a_D*x^D + ... + a_0, one MAC per cycle.
// Operands are loaded over a shared bus with a press/release go handshake.
module poly_eval #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             keep_coef,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       phase,
    output logic [3:0]       load_idx
);

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_X_WAIT,
        S_LOAD_C,
        S_LOAD_C_WAIT,
        S_INIT,
        S_STEP
    } state_t;

    localparam logic [3:0] D = 4'(DEGREE);
    localparam int FW = 2 * WIDTH + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] coef [0:DEGREE];
    logic             coef_valid;
    logic [3:0]       idx;
    logic [3:0]       k;
    logic             ovf;
    logic [WIDTH-1:0] coef_k;
    logic [FW-1:0]    full;
    logic             full_ovf;

    // Explicit compare-mux keeps the 4-bit k index independent of the array depth.
    always_comb begin
        coef_k = '0;
        for (int unsigned i = 0; i < DEGREE + 1; i++)
            if (k == 4'(i)) coef_k = coef[i];
    end

    always_comb begin
        full     = FW'(acc) * FW'(x) + FW'(coef_k);
        full_ovf = |full[FW-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD_X;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        phase    = 2'd0;
        load_idx = 4'd0;
        case (state)
            S_LOAD_X:      if (go) state_nx = S_LOAD_X_WAIT;
            S_LOAD_X_WAIT: if (!go) state_nx = (keep_coef && coef_valid) ? S_INIT : S_LOAD_C;
            S_LOAD_C: begin
                phase    = 2'd1;
                load_idx = idx;
                if (go) state_nx = S_LOAD_C_WAIT;
            end
            S_LOAD_C_WAIT: begin
                phase    = 2'd1;
                load_idx = idx;
                if (!go) state_nx = (idx == 4'd0) ? S_INIT : S_LOAD_C;
            end
            S_INIT: begin
                busy     = 1'b1;
                phase    = 2'd2;
                state_nx = S_STEP;
            end
            S_STEP: begin
                busy  = 1'b1;
                phase = 2'd2;
                if (k == 4'd0) state_nx = S_LOAD_X;
            end
            default: state_nx = S_LOAD_X;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x            <= '0;
            acc          <= '0;
            coef_valid   <= 1'b0;
            idx          <= 4'd0;
            k            <= 4'd0;
            ovf          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            for (int unsigned i = 0; i < DEGREE + 1; i++) coef[i] <= '0;
        end else begin
            case (state)
                S_LOAD_X: begin
                    if (go) begin
                        x            <= data_in;
                        result_valid <= 1'b0;
                    end
                end
                S_LOAD_X_WAIT: begin
                    if (!go && !(keep_coef && coef_valid)) idx <= D;
                end
                S_LOAD_C: begin
                    if (go) begin
                        for (int unsigned i = 0; i < DEGREE + 1; i++)
                            if (idx == 4'(i)) coef[i] <= data_in;
                    end
                end
                S_LOAD_C_WAIT: begin
                    if (!go) begin
                        if (idx == 4'd0) coef_valid <= 1'b1;
                        else             idx <= idx - 4'd1;
                    end
                end
                S_INIT: begin
                    acc <= coef[DEGREE];
                    k   <= D - 4'd1;
                    ovf <= 1'b0;
                end
                S_STEP: begin
                    acc <= full[WIDTH-1:0];
                    if (full_ovf) ovf <= 1'b1;
                    if (k == 4'd0) begin
                        result       <= full[WIDTH-1:0];
                        overflow     <= ovf | full_ovf;
                        result_valid <= 1'b1;
                    end else begin
                        k <= k - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval.sv
// Directed bench for poly_eval: an 8-bit quadratic instance and a 16-bit cubic
// instance share the input bus; expected values are hand-computed Horner results.
module tb_poly_eval;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        keep_coef = 1'b0;
    logic [15:0] din = '0;

    logic [7:0]  res_a;
    logic        rv_a, ov_a, busy_a;
    logic [1:0]  ph_a;
    logic [3:0]  li_a;
    logic [15:0] res_b;
    logic        rv_b, ov_b, busy_b;
    logic [1:0]  ph_b;
    logic [3:0]  li_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    poly_eval #(.WIDTH(8), .DEGREE(2)) dut_a (
        .clk(clk), .reset(reset), .go(go), .keep_coef(keep_coef), .data_in(din[7:0]),
        .result(res_a), .result_valid(rv_a), .overflow(ov_a), .busy(busy_a),
        .phase(ph_a), .load_idx(li_a)
    );

    poly_eval #(.WIDTH(16), .DEGREE(3)) dut_b (
        .clk(clk), .reset(reset), .go(go), .keep_coef(keep_coef), .data_in(din),
        .result(res_b), .result_valid(rv_b), .overflow(ov_b), .busy(busy_b),
        .phase(ph_b), .load_idx(li_b)
    );

    // One press/release slot: go high for one rising edge, then low.
    task automatic press(input logic [15:0] v);
        @(negedge clk);
        din = v;
        go  = 1'b1;
        @(negedge clk);
        go  = 1'b0;
    endtask

    // Waits for result_valid on the chosen instance; cyc = edges after go release (0 = timeout).
    task automatic wait_done(input bit big, output int cyc, output int bcnt, output logic [1:0] fphase);
        cyc = 0;
        bcnt = 0;
        fphase = 2'd3;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) fphase = big ? ph_b : ph_a;
            if (big ? busy_b : busy_a) bcnt++;
            if (big ? rv_b : rv_a) begin
                cyc = i - 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({res_a, rv_a, ov_a, busy_a, ph_a, li_a} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_a: got %h, want 0", {res_a, rv_a, ov_a, busy_a, ph_a, li_a});
        end
        vectors++;
        if ({res_b, rv_b, ov_b, busy_b, ph_b, li_b} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_b: got %h, want 0", {res_b, rv_b, ov_b, busy_b, ph_b, li_b});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        logic [1:0] fp;
        keep_coef = 1'b0;
        press(16'd3);
        @(negedge clk);
        vectors++;
        if (ph_a !== 2'd1 || li_a !== 4'd2) begin
            miscompares++;
            $display("FAIL basic_load_phase: got phase=%0d idx=%0d, want 1/2", ph_a, li_a);
        end
        press(16'd2);
        @(negedge clk);
        vectors++;
        if (li_a !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_load_idx1: got %0d, want 1", li_a);
        end
        press(16'd5);
        press(16'd7);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (res_a !== 8'h28 || ov_a !== 1'b0 || rv_a !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_result: got %h ov=%b rv=%b, want 28 ov=0 rv=1", res_a, ov_a, rv_a);
        end
        vectors++;
        if (cyc !== 3 || bcnt !== 3) begin
            miscompares++;
            $display("FAIL basic_timing: got latency=%0d busy=%0d, want 3/3", cyc, bcnt);
        end
    endtask

    task automatic test_keep_coef();
        int cyc, bcnt;
        logic [1:0] fp;
        keep_coef = 1'b1;
        press(16'd4);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (fp !== 2'd2 || cyc !== 3) begin
            miscompares++;
            $display("FAIL keep_phase: got phase=%0d latency=%0d, want 2/3", fp, cyc);
        end
        vectors++;
        if (res_a !== 8'h3B || ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL keep_result: got %h ov=%b, want 3b ov=0", res_a, ov_a);
        end
        keep_coef = 1'b0;
    endtask

    task automatic test_overflow();
        int cyc, bcnt;
        logic [1:0] fp;
        keep_coef = 1'b0;
        press(16'd16);
        press(16'd1);
        press(16'd0);
        press(16'd0);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (cyc == 0 || res_a !== 8'h00 || ov_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %h ov=%b lat=%0d, want 00 ov=1", res_a, ov_a, cyc);
        end
        keep_coef = 1'b1;
        press(16'd1);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (cyc == 0 || res_a !== 8'h01 || ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h ov=%b lat=%0d, want 01 ov=0", res_a, ov_a, cyc);
        end
        keep_coef = 1'b0;
    endtask

    task automatic test_keep_after_reset();
        int cyc, bcnt;
        logic [1:0] fp;
        do_reset();
        keep_coef = 1'b1;
        press(16'd3);
        @(negedge clk);
        vectors++;
        if (ph_a !== 2'd1 || li_a !== 4'd2) begin
            miscompares++;
            $display("FAIL keep_ignored: got phase=%0d idx=%0d, want 1/2", ph_a, li_a);
        end
        press(16'd0);
        press(16'd0);
        press(16'd9);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (cyc == 0 || res_a !== 8'h09) begin
            miscompares++;
            $display("FAIL keep_ignored_result: got %h lat=%0d, want 09", res_a, cyc);
        end
        keep_coef = 1'b0;
    endtask

    task automatic test_reset_mid_compute();
        int cyc, bcnt;
        logic [1:0] fp;
        do_reset();
        keep_coef = 1'b0;
        press(16'd3);
        press(16'd2);
        press(16'd5);
        press(16'd7);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got %b, want 1", busy_a);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({res_a, rv_a, ov_a, busy_a, ph_a, li_a} !== 17'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h, want 0", {res_a, rv_a, ov_a, busy_a, ph_a, li_a});
        end
        keep_coef = 1'b1;
        press(16'd4);
        @(negedge clk);
        vectors++;
        if (ph_a !== 2'd1 || li_a !== 4'd2) begin
            miscompares++;
            $display("FAIL mid_reload_required: got phase=%0d idx=%0d, want 1/2", ph_a, li_a);
        end
        press(16'd2);
        press(16'd5);
        press(16'd7);
        wait_done(1'b0, cyc, bcnt, fp);
        vectors++;
        if (cyc == 0 || res_a !== 8'h3B) begin
            miscompares++;
            $display("FAIL mid_reload_result: got %h lat=%0d, want 3b", res_a, cyc);
        end
        keep_coef = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        logic [1:0] fp;
        bit seen;
        do_reset();
        keep_coef = 1'b0;
        press(16'd2);
        press(16'd1);
        press(16'd2);
        press(16'd3);
        @(negedge clk);
        din = 16'd4;
        go  = 1'b1;
        @(negedge clk);
        go  = 1'b0;
        @(negedge clk);
        din = 16'd7;
        go  = 1'b1;
        keep_coef = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv_b) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || res_b !== 16'h001A || ov_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: got %h ov=%b seen=%b, want 001a ov=0", res_b, ov_b, seen);
        end
        @(negedge clk);
        vectors++;
        if (rv_b !== 1'b0 || ph_b !== 2'd0 || res_b !== 16'h001A) begin
            miscompares++;
            $display("FAIL b2b_capture: got rv=%b phase=%0d res=%h, want 0/0/001a", rv_b, ph_b, res_b);
        end
        go = 1'b0;
        wait_done(1'b1, cyc, bcnt, fp);
        vectors++;
        if (res_b !== 16'h01D2 || fp !== 2'd2 || cyc !== 4 || bcnt !== 4) begin
            miscompares++;
            $display("FAIL b2b_second: got %h phase=%0d lat=%0d busy=%0d, want 01d2/2/4/4",
                     res_b, fp, cyc, bcnt);
        end
        keep_coef = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_keep_coef();
        test_overflow();
        test_keep_after_reset();
        test_reset_mid_compute();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
